mips_run_ctrl: RTL

Parametrised run controller for the pipelined MIPS core. It sequences core reset, gates core advance with a clock enable, and stops the run on a halt PC or a cycle-limit timeout. It judges pass/fail from a data-memory mailbox store. It sits between the system clock/reset and `mips_top`, replacing fixed-address, fixed-duration run loops with a synthesizable, reusable block. Optionally it supports single-step execution.

---
 rtl/mips_run_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined MIPS core: core reset sequencing, clock-enable gating,
// halt/timeout stop and mailbox pass/fail. Optional single-step gating under RUN_CTRL_STEP_EN.
module mips_run_ctrl #(
   parameter int unsigned          PC_W       = 32,
   parameter logic [PC_W-1:0]      HALT_PC    = 'h10,
   parameter logic [PC_W-1:0]      MBOX_ADDR  = 'hFC,
   parameter logic [PC_W-1:0]      PASS_CODE  = 'h1,
   parameter int unsigned          RST_CYCLES = 2,
   parameter int unsigned          MAX_CYCLES = 1024,
   parameter int unsigned          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_mode,
   input  logic             step,
   input  logic [PC_W-1:0]  pc_current,
   input  logic             we_dm,
   input  logic [PC_W-1:0]  alu_out,
   input  logic [PC_W-1:0]  wd_dm,
   output logic             core_rst,
   output logic             core_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             timeout,
   output logic [PC_W-1:0]  mbox,
   output logic [CNT_W-1:0] cycle_count
);

   localparam logic [7:0]       RstLast = 8'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] MaxCnt  = CNT_W'(MAX_CYCLES);

   typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [7:0]       rst_cnt_q, rst_cnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PC_W-1:0]  mbox_q, mbox_d;
   logic             seen_q, seen_d;
   logic             pass_q, pass_d;
   logic             timeout_q, timeout_d;

   logic step_active;
   logic halt_hit;
   logic timeout_hit;
   logic mbox_store;

`ifdef RUN_CTRL_STEP_EN
   assign step_active = step_mode;
`else
   assign step_active = 1'b0;
   logic unused_step;
   assign unused_step = step_mode ^ step;
`endif

   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      cnt_d     = cnt_q;
      mbox_d    = mbox_q;
      seen_d    = seen_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;

      halt_hit    = (state_q == StRun) && (pc_current == HALT_PC);
      timeout_hit = (state_q == StRun) && (cnt_q == MaxCnt) && !halt_hit;
      // Timeout also freezes the core so the counter stops exactly at the limit.
      core_en     = (state_q == StRun) && !halt_hit && !timeout_hit && (!step_active || step);
      mbox_store  = we_dm && core_en && (alu_out == MBOX_ADDR);

      if (core_en) cnt_d = cnt_q + 1'b1;
      if (mbox_store) begin
         mbox_d = wd_dm;
         seen_d = 1'b1;
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StReset;
               rst_cnt_d = '0;
               cnt_d     = '0;
               mbox_d    = '0;
               seen_d    = 1'b0;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         StReset: begin
            if (rst_cnt_q == RstLast) state_d = StRun;
            else                      rst_cnt_d = rst_cnt_q + 1'b1;
         end
         StRun: begin
            if (halt_hit || timeout_hit) begin
               state_d   = StDone;
               timeout_d = timeout_hit;
               pass_d    = !timeout_hit && seen_d && (mbox_d == PASS_CODE);
            end
         end
         default: state_d = StIdle;
      endcase

      core_rst = (state_q == StIdle) || (state_q == StReset);
      busy     = (state_q == StReset) || (state_q == StRun);
      done     = (state_q == StDone);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         rst_cnt_q <= '0;
         cnt_q     <= '0;
         mbox_q    <= '0;
         seen_q    <= 1'b0;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         cnt_q     <= cnt_d;
         mbox_q    <= mbox_d;
         seen_q    <= seen_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
      end
   end

   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign mbox        = mbox_q;
   assign cycle_count = cnt_q;

endmodule
